// File: rtl/frogger_pkg.sv
// Shared playfield constants and hop-direction encoding for the frogger blocks
// (frog controller, collision, traffic).
package frogger_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FROG_SIZE = 16;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw push button followed by a registered
// single-cycle rising-edge pulse (pulse appears 3 clk after the raw rise).
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta   <= btn;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/frog_controller.sv
// Frog position owner: turns button edges into single hops, applies them at the
// start of vertical blank, and draws the frog sprite flag for collision.
module frog_controller
    import frogger_pkg::*;
#(
    parameter int STEP        = 16,
    parameter int START_X     = 312,
    parameter int START_Y     = 464,
    parameter int HOLD_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       freeze,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    output logic       frog,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [7:0] hops
);

    localparam int          CD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SIZE_W = 11'(FROG_SIZE);
    localparam logic [10:0] MAX_X  = 11'(SCREEN_W - FROG_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(SCREEN_H - FROG_SIZE);

    logic            pulse_up, pulse_down, pulse_left, pulse_right;
    dir_t            edge_dir;
    dir_t            pending;
    logic [CD_W-1:0] cooldown;
    logic [9:0]      nx, ny;
    logic            moved;
    logic            apply_pt;
    logic [10:0]     x_w, y_w, xc_w, yc_w;

    btn_edge u_edge_up    (.clk(clk), .rst(rst), .btn(btn_up),    .pulse(pulse_up));
    btn_edge u_edge_down  (.clk(clk), .rst(rst), .btn(btn_down),  .pulse(pulse_down));
    btn_edge u_edge_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(pulse_left));
    btn_edge u_edge_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(pulse_right));

    // Simultaneous edges resolve UP > DOWN > LEFT > RIGHT; losers are dropped.
    always_comb begin
        edge_dir = DIR_NONE;
        if (pulse_up)
            edge_dir = DIR_UP;
        else if (pulse_down)
            edge_dir = DIR_DOWN;
        else if (pulse_left)
            edge_dir = DIR_LEFT;
        else if (pulse_right)
            edge_dir = DIR_RIGHT;
    end

    assign x_w  = {1'b0, frog_x};
    assign y_w  = {1'b0, frog_y};
    assign xc_w = {1'b0, xCount};
    assign yc_w = {1'b0, yCount};

    // Candidate position for the pending hop; a hop that would leave the field is a no-op.
    always_comb begin
        nx = frog_x;
        ny = frog_y;
        case (pending)
            DIR_UP:    if (y_w >= STEP_W)          ny = 10'(y_w - STEP_W);
            DIR_DOWN:  if (y_w + STEP_W <= MAX_Y)  ny = 10'(y_w + STEP_W);
            DIR_LEFT:  if (x_w >= STEP_W)          nx = 10'(x_w - STEP_W);
            DIR_RIGHT: if (x_w + STEP_W <= MAX_X)  nx = 10'(x_w + STEP_W);
            default: ;
        endcase
    end

    assign moved    = (nx != frog_x) || (ny != frog_y);
    assign apply_pt = (xCount == 10'd0) && (yCount == 10'(SCREEN_H));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frog_x   <= 10'(START_X);
            frog_y   <= 10'(START_Y);
            hops     <= 8'd0;
            pending  <= DIR_NONE;
            cooldown <= '0;
        end else begin
            if (cooldown != '0)
                cooldown <= cooldown - 1'b1;

            // Apply wins over accept: a new edge can only be taken once nothing is pending.
            if (apply_pt && pending != DIR_NONE) begin
                pending <= DIR_NONE;
                if (!freeze && moved) begin
                    frog_x <= nx;
                    frog_y <= ny;
                    if (hops != 8'hFF)
                        hops <= hops + 8'd1;
                end
            end else if (!freeze && cooldown == '0 && pending == DIR_NONE
                         && edge_dir != DIR_NONE) begin
                pending  <= edge_dir;
                cooldown <= CD_W'(HOLD_CYCLES - 1);
            end
        end
    end

    assign frog = (xc_w >= x_w) && (xc_w < x_w + SIZE_W) &&
                  (yc_w >= y_w) && (yc_w < y_w + SIZE_W);

endmodule

// File: tb/tb_frog_controller.sv
// Randomized and directed bench for frog_controller against an event-level model
// of hop acceptance, vblank application and sprite coverage.
module tb_frog_controller;

    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       freeze;
    logic [9:0] cx, cy;
    logic       frog;
    logic [9:0] frog_x, frog_y;
    logic [7:0] hops;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    // Reference model state
    int   m_x = 312, m_y = 464, m_hops = 0, m_pend = 0, m_next_ok = 0, cyc = 0;
    logic [3:0] h1 = '0, h2 = '0, h3 = '0, h4 = '0;

    frog_controller #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .freeze(freeze), .xCount(cx), .yCount(cy),
        .frog(frog), .frog_x(frog_x), .frog_y(frog_y), .hops(hops)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Button edges are seen 3 clk after the raw rise, so a raw sample rising
    // three edges ago is an edge candidate on this edge.
    always @(posedge clk or negedge rst) begin
        int   tx, ty, old_pend;
        logic [3:0] e;
        if (!rst) begin
            m_x = 312; m_y = 464; m_hops = 0; m_pend = 0; m_next_ok = 0; cyc = 0;
            h1 = '0; h2 = '0; h3 = '0; h4 = '0;
        end else begin
            cyc++;
            e = h3 & ~h4;
            old_pend = m_pend;
            if (int'(cx) == 0 && int'(cy) == 480 && old_pend != 0) begin
                if (!freeze) begin
                    tx = m_x; ty = m_y;
                    case (old_pend)
                        1: if (ty >= 16)        ty = ty - 16;
                        2: if (ty + 16 <= 464)  ty = ty + 16;
                        3: if (tx >= 16)        tx = tx - 16;
                        4: if (tx + 16 <= 624)  tx = tx + 16;
                        default: ;
                    endcase
                    if (tx != m_x || ty != m_y) begin
                        m_x = tx; m_y = ty;
                        if (m_hops < 255) m_hops++;
                    end
                end
                m_pend = 0;
            end
            if (!freeze && cyc >= m_next_ok && old_pend == 0 && e != 0) begin
                m_pend    = e[0] ? 1 : e[1] ? 2 : e[2] ? 3 : 4;
                m_next_ok = cyc + HOLD;
            end
            h4 = h3; h3 = h2; h2 = h1;
            h1 = {btn_right, btn_left, btn_down, btn_up};
        end
    end

    always @(negedge clk) begin
        logic exp_frog;
        if (cmp_en) begin
            exp_frog = (int'(cx) >= m_x) && (int'(cx) < m_x + 16) &&
                       (int'(cy) >= m_y) && (int'(cy) < m_y + 16);
            check("cyc_frog_x", frog_x, m_x);
            check("cyc_frog_y", frog_y, m_y);
            check("cyc_hops",   hops,   m_hops);
            check("cyc_frog",   frog,   exp_frog);
        end
    end

    // Free-running 800x525 scan counter, advanced once per clock.
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
            if (cx == 10'd799) begin
                cx = 10'd0;
                cy = (cy == 10'd524) ? 10'd0 : cy + 10'd1;
            end else begin
                cx = cx + 10'd1;
            end
        end
    endtask

    task automatic to_vblank();
        cx = 10'd795;
        cy = 10'd479;
        step(12);
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        {btn_right, btn_left, btn_down, btn_up} = mask;
        step(hold);
        {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
        step(10);
    endtask

    initial begin
        int sx, sy, sh;
        rst = 1'b1;
        {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
        freeze = 1'b0;
        cx = 10'd0;
        cy = 10'd0;
        #1 rst = 1'b0;
        step(3);
        check("reset_x", frog_x, 312);
        check("reset_y", frog_y, 464);
        check("reset_hops", hops, 0);
        cmp_en = 1'b1;
        rst = 1'b1;
        step(2);

        // First hop applied by a forced apply point, then a re-press inside cooldown
        btn_up = 1'b1;
        step(4);
        cx = 10'd0; cy = 10'd480;
        btn_up = 1'b0;
        step(1);
        btn_up = 1'b1;
        step(2);
        btn_up = 1'b0;
        step(10);
        check("up1_y", frog_y, 448);
        check("up1_x", frog_x, 312);
        check("up1_hops", hops, 1);
        to_vblank();
        to_vblank();
        check("cooldown_drop_y", frog_y, 448);
        check("cooldown_drop_hops", hops, 1);

        cmp_en = 1'b0;
        for (int yy = 444; yy <= 467; yy++) begin
            for (int xx = 308; xx <= 331; xx++) begin
                cx = 10'(xx); cy = 10'(yy);
                #1 check("sprite_sweep", frog,
                         (xx >= 312 && xx <= 327 && yy >= 448 && yy <= 463) ? 1 : 0);
            end
        end
        step(1);
        cmp_en = 1'b1;

        // UP and LEFT in the same clock: UP wins
        press(4'b0101, 2);
        to_vblank();
        check("prio_y", frog_y, 432);
        check("prio_x", frog_x, 312);
        check("prio_hops", hops, 2);

        // Walk right to the edge; 312 + 19*16 = 616 is the last legal x
        for (int i = 0; i < 19; i++) begin
            press(4'b1000, 2);
            to_vblank();
        end
        check("walk_right_x", frog_x, 616);
        check("walk_right_hops", hops, 21);
        press(4'b1000, 2);
        to_vblank();
        check("right_block_x", frog_x, 616);
        check("right_block_hops", hops, 21);
        press(4'b0100, 2);
        to_vblank();
        check("left_after_block_x", frog_x, 600);
        check("left_after_block_hops", hops, 22);

        // Walk to the top row, then one more blocked UP
        for (int i = 0; i < 28; i++) begin
            press(4'b0001, 2);
            to_vblank();
        end
        check("top_y", frog_y, 0);
        check("top_hops", hops, 49);

        // Randomized buttons, freeze and vblank timing
        for (int i = 0; i < 250; i++) begin
            {btn_right, btn_left, btn_down, btn_up} = 4'($urandom_range(0, 15));
            freeze = ($urandom_range(0, 7) == 0);
            step($urandom_range(1, 6));
            {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
            step($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) to_vblank();
        end
        freeze = 1'b0;
        to_vblank();
        step(10);

        // Accept DOWN, then freeze before vblank
        sx = m_x; sy = m_y; sh = m_hops;
        btn_down = 1'b1;
        step(5);
        btn_down = 1'b0;
        freeze = 1'b1;
        step(3);
        to_vblank();
        check("freeze_x", frog_x, sx);
        check("freeze_y", frog_y, sy);
        check("freeze_hops", hops, sh);
        press(4'b0001, 2);
        press(4'b0100, 2);
        to_vblank();
        to_vblank();
        check("freeze_ignore_y", frog_y, sy);
        check("freeze_ignore_x", frog_x, sx);
        check("freeze_ignore_hops", hops, sh);
        freeze = 1'b0;
        to_vblank();
        check("unfreeze_no_stale_y", frog_y, sy);
        step(10);

        // Reset mid-cooldown with a pending hop
        btn_up = 1'b1;
        step(5);
        rst = 1'b0;
        #1;
        check("rst_mid_x", frog_x, 312);
        check("rst_mid_y", frog_y, 464);
        check("rst_mid_hops", hops, 0);
        btn_up = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        press(4'b0001, 2);
        to_vblank();
        check("post_rst_y", frog_y, 448);
        check("post_rst_x", frog_x, 312);
        check("post_rst_hops", hops, 1);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
